// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline register.
// Provides the datapath widths, the reset PC defaults, the load-extension
// encodings, the packed field-group bundles with their NOP values, and a
// helper that summarises the exception flags of a side-effect bundle.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int HILO_W = 64;
  localparam int WDS_W  = 4;
  localparam int WEN_W  = 4;
  localparam int DST_W  = 5;
  localparam int EXT_W  = 3;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] RESET_PC4_DEF = 32'hBFC0_0004;

  // Load extension operations carried to the MEM stage.
  typedef enum logic [EXT_W-1:0] {
    EXT_LB  = 3'b000,
    EXT_LBU = 3'b001,
    EXT_LH  = 3'b010,
    EXT_LHU = 3'b011,
    EXT_LW  = 3'b100
  } ext_op_e;

  // Fields that only carry data; they load even for an invalid slot.
  typedef struct packed {
    logic [XLEN-1:0]   inst;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_s;
    logic [XLEN-1:0]   alu_c;
    logic [HILO_W-1:0] hilo;
    logic [EXT_W-1:0]  ext_op;
    logic [WDS_W-1:0]  wds;
  } dp_t;

  // Fields that change architectural state or raise exceptions; these are
  // zeroed whenever the slot does not hold a real instruction.
  typedef struct packed {
    logic [WEN_W-1:0] wen;
    logic [1:0]       write_hilo;
    logic             write_reg;
    logic             write_cp0reg;
    logic [DST_W-1:0] write_dst;
    logic             trap;
    logic             if_addr_fault;
    logic             ri_fault;
    logic             soft_int;
    logic             overflow;
    logic             delay_slot;
  } side_t;

  localparam dp_t   DP_NOP   = '0;
  localparam side_t SIDE_NOP = '0;

  // Any exception flag raised in the bundle (delay_slot is status only).
  function automatic logic exc_summary(input side_t s);
    return s.trap | s.if_addr_fault | s.ri_fault | s.soft_int | s.overflow;
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Register for one field group of a pipeline register.
// Ports: clk_i/rst_ni clock and async active-low reset, clear_i loads
// RST_VAL, hold_i keeps the current value, otherwise d_i is captured.
// q_o is the registered value. clear_i takes priority over hold_i.
module pipe_field_reg #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         hold_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Field storage: reset/clear to RST_VAL, hold, or load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RST_VAL;
    end else if (clear_i) begin
      q_q <= RST_VAL;
    end else if (hold_i) begin
      q_q <= q_q;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the 5-stage MIPS pipeline.
// Captures the EX result bundle each rising edge and presents it to MEM.
// Controls: flush (kill, load NOP) > stall (hold all) > bubble (load NOP)
// > load. An invalid EX slot loads its datapath fields but has all
// side-effect fields forced to zero. exc_pending summarises the registered
// exception flags of a valid MEM slot.
// Ports: clk, rst_n, stall, bubble, flush, ex_valid, mem_valid, and the
// *_in / *_out pairs of the EX result bundle.
module ex_mem_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] RESET_PC4 = RESET_PC4_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        bubble,
  input  logic        flush,
  input  logic        ex_valid,
  output logic        mem_valid,
  input  logic [31:0] PC_in,
  output logic [31:0] PC_out,
  input  logic [31:0] PC4_in,
  output logic [31:0] PC4_out,
  input  logic [31:0] Inst_in,
  output logic [31:0] Inst_out,
  input  logic [3:0]  data_sram_wen_in,
  output logic [3:0]  data_sram_wen_out,
  input  logic [31:0] data_sram_wdata_in,
  output logic [31:0] data_sram_wdata_out,
  input  logic [31:0] reg_data1_in,
  output logic [31:0] reg_data1_out,
  input  logic [31:0] reg_data2_in,
  output logic [31:0] reg_data2_out,
  input  logic [31:0] alu_a_in,
  output logic [31:0] alu_a_out,
  input  logic [31:0] alu_s_in,
  output logic [31:0] alu_s_out,
  input  logic [31:0] alu_c_in,
  output logic [31:0] alu_c_out,
  input  logic [63:0] hilo_in,
  output logic [63:0] hilo_out,
  input  logic [1:0]  write_hilo_in,
  output logic [1:0]  write_hilo_out,
  input  logic        write_reg_in,
  output logic        write_reg_out,
  input  logic        write_cp0reg_in,
  output logic        write_cp0reg_out,
  input  logic [4:0]  write_dst_in,
  output logic [4:0]  write_dst_out,
  input  logic [2:0]  extOp_in,
  output logic [2:0]  extOp_out,
  input  logic [3:0]  write_data_src_in,
  output logic [3:0]  write_data_src_out,
  input  logic        trap_in,
  output logic        trap_out,
  input  logic        IF_addr_fault_in,
  output logic        IF_addr_fault_out,
  input  logic        ri_fault_in,
  output logic        ri_fault_out,
  input  logic        soft_int_in,
  output logic        soft_int_out,
  input  logic        overflow_in,
  output logic        overflow_out,
  input  logic        delay_slot_in,
  output logic        delay_slot_out,
  output logic        exc_pending
);

  logic  clear_d;
  logic  hold_d;
  dp_t   dp_d;
  dp_t   dp_q;
  side_t side_d;
  side_t side_q;
  logic  valid_q;

  // Priority decode of the per-cycle action; stall beats bubble.
  always_comb begin
    clear_d = 1'b0;
    hold_d  = 1'b0;
    if (flush) begin
      clear_d = 1'b1;
    end else if (stall) begin
      hold_d = 1'b1;
    end else if (bubble) begin
      clear_d = 1'b1;
    end else begin
      clear_d = 1'b0;
      hold_d  = 1'b0;
    end
  end

  // Datapath bundle loads unconditionally.
  always_comb begin
    dp_d        = DP_NOP;
    dp_d.inst   = Inst_in;
    dp_d.wdata  = data_sram_wdata_in;
    dp_d.rd1    = reg_data1_in;
    dp_d.rd2    = reg_data2_in;
    dp_d.alu_a  = alu_a_in;
    dp_d.alu_s  = alu_s_in;
    dp_d.alu_c  = alu_c_in;
    dp_d.hilo   = hilo_in;
    dp_d.ext_op = extOp_in;
    dp_d.wds    = write_data_src_in;
  end

  // Side-effect bundle: zero for an invalid slot; write_dst is zeroed
  // whenever write_reg is, so forwarding never matches a dead write.
  always_comb begin
    side_d = SIDE_NOP;
    if (ex_valid) begin
      side_d.wen           = data_sram_wen_in;
      side_d.write_hilo    = write_hilo_in;
      side_d.write_reg     = write_reg_in;
      side_d.write_cp0reg  = write_cp0reg_in;
      side_d.write_dst     = write_reg_in ? write_dst_in : 5'd0;
      side_d.trap          = trap_in;
      side_d.if_addr_fault = IF_addr_fault_in;
      side_d.ri_fault      = ri_fault_in;
      side_d.soft_int      = soft_int_in;
      side_d.overflow      = overflow_in;
      side_d.delay_slot    = delay_slot_in;
    end else begin
      side_d = SIDE_NOP;
    end
  end

  pipe_field_reg #(.W(32), .RST_VAL(RESET_PC)) u_pc (
    .clk_i(clk), .rst_ni(rst_n), .hold_i(hold_d), .clear_i(clear_d),
    .d_i(PC_in), .q_o(PC_out)
  );

  pipe_field_reg #(.W(32), .RST_VAL(RESET_PC4)) u_pc4 (
    .clk_i(clk), .rst_ni(rst_n), .hold_i(hold_d), .clear_i(clear_d),
    .d_i(PC4_in), .q_o(PC4_out)
  );

  pipe_field_reg #(.W($bits(dp_t)), .RST_VAL(DP_NOP)) u_dp (
    .clk_i(clk), .rst_ni(rst_n), .hold_i(hold_d), .clear_i(clear_d),
    .d_i(dp_d), .q_o(dp_q)
  );

  pipe_field_reg #(.W($bits(side_t)), .RST_VAL(SIDE_NOP)) u_side (
    .clk_i(clk), .rst_ni(rst_n), .hold_i(hold_d), .clear_i(clear_d),
    .d_i(side_d), .q_o(side_q)
  );

  pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk_i(clk), .rst_ni(rst_n), .hold_i(hold_d), .clear_i(clear_d),
    .d_i(ex_valid), .q_o(valid_q)
  );

  assign mem_valid           = valid_q;
  assign Inst_out            = dp_q.inst;
  assign data_sram_wdata_out = dp_q.wdata;
  assign reg_data1_out       = dp_q.rd1;
  assign reg_data2_out       = dp_q.rd2;
  assign alu_a_out           = dp_q.alu_a;
  assign alu_s_out           = dp_q.alu_s;
  assign alu_c_out           = dp_q.alu_c;
  assign hilo_out            = dp_q.hilo;
  assign extOp_out           = dp_q.ext_op;
  assign write_data_src_out  = dp_q.wds;
  assign data_sram_wen_out   = side_q.wen;
  assign write_hilo_out      = side_q.write_hilo;
  assign write_reg_out       = side_q.write_reg;
  assign write_cp0reg_out    = side_q.write_cp0reg;
  assign write_dst_out       = side_q.write_dst;
  assign trap_out            = side_q.trap;
  assign IF_addr_fault_out   = side_q.if_addr_fault;
  assign ri_fault_out        = side_q.ri_fault;
  assign soft_int_out        = side_q.soft_int;
  assign overflow_out        = side_q.overflow;
  assign delay_slot_out      = side_q.delay_slot;

  // Built from registered state only, so no input reaches it this cycle.
  assign exc_pending = valid_q & exc_summary(side_q);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, load, stall, flush, invalid slot,
// bubble, stall+bubble and reset release under stall.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall, bubble, flush, ex_valid, mem_valid;
  logic [31:0] PC_in, PC_out, PC4_in, PC4_out, Inst_in, Inst_out;
  logic [3:0]  data_sram_wen_in, data_sram_wen_out;
  logic [31:0] data_sram_wdata_in, data_sram_wdata_out;
  logic [31:0] reg_data1_in, reg_data1_out, reg_data2_in, reg_data2_out;
  logic [31:0] alu_a_in, alu_a_out, alu_s_in, alu_s_out, alu_c_in, alu_c_out;
  logic [63:0] hilo_in, hilo_out;
  logic [1:0]  write_hilo_in, write_hilo_out;
  logic        write_reg_in, write_reg_out, write_cp0reg_in, write_cp0reg_out;
  logic [4:0]  write_dst_in, write_dst_out;
  logic [2:0]  extOp_in, extOp_out;
  logic [3:0]  write_data_src_in, write_data_src_out;
  logic        trap_in, trap_out, IF_addr_fault_in, IF_addr_fault_out;
  logic        ri_fault_in, ri_fault_out, soft_int_in, soft_int_out;
  logic        overflow_in, overflow_out, delay_slot_in, delay_slot_out;
  logic        exc_pending;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RPC  = 32'hBFC0_0000;
  localparam logic [31:0] RPC4 = 32'hBFC0_0004;

  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble), .flush(flush),
    .ex_valid(ex_valid), .mem_valid(mem_valid),
    .PC_in(PC_in), .PC_out(PC_out), .PC4_in(PC4_in), .PC4_out(PC4_out),
    .Inst_in(Inst_in), .Inst_out(Inst_out),
    .data_sram_wen_in(data_sram_wen_in), .data_sram_wen_out(data_sram_wen_out),
    .data_sram_wdata_in(data_sram_wdata_in), .data_sram_wdata_out(data_sram_wdata_out),
    .reg_data1_in(reg_data1_in), .reg_data1_out(reg_data1_out),
    .reg_data2_in(reg_data2_in), .reg_data2_out(reg_data2_out),
    .alu_a_in(alu_a_in), .alu_a_out(alu_a_out),
    .alu_s_in(alu_s_in), .alu_s_out(alu_s_out),
    .alu_c_in(alu_c_in), .alu_c_out(alu_c_out),
    .hilo_in(hilo_in), .hilo_out(hilo_out),
    .write_hilo_in(write_hilo_in), .write_hilo_out(write_hilo_out),
    .write_reg_in(write_reg_in), .write_reg_out(write_reg_out),
    .write_cp0reg_in(write_cp0reg_in), .write_cp0reg_out(write_cp0reg_out),
    .write_dst_in(write_dst_in), .write_dst_out(write_dst_out),
    .extOp_in(extOp_in), .extOp_out(extOp_out),
    .write_data_src_in(write_data_src_in), .write_data_src_out(write_data_src_out),
    .trap_in(trap_in), .trap_out(trap_out),
    .IF_addr_fault_in(IF_addr_fault_in), .IF_addr_fault_out(IF_addr_fault_out),
    .ri_fault_in(ri_fault_in), .ri_fault_out(ri_fault_out),
    .soft_int_in(soft_int_in), .soft_int_out(soft_int_out),
    .overflow_in(overflow_in), .overflow_out(overflow_out),
    .delay_slot_in(delay_slot_in), .delay_slot_out(delay_slot_out),
    .exc_pending(exc_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; bubble = 1'b0; flush = 1'b0; ex_valid = 1'b0;
    PC_in = 32'h0; PC4_in = 32'h0; Inst_in = 32'h0;
    data_sram_wen_in = 4'h0; data_sram_wdata_in = 32'h0;
    reg_data1_in = 32'h0; reg_data2_in = 32'h0;
    alu_a_in = 32'h0; alu_s_in = 32'h0; alu_c_in = 32'h0; hilo_in = 64'h0;
    write_hilo_in = 2'b00; write_reg_in = 1'b0; write_cp0reg_in = 1'b0;
    write_dst_in = 5'd0; extOp_in = 3'b000; write_data_src_in = 4'h0;
    trap_in = 1'b0; IF_addr_fault_in = 1'b0; ri_fault_in = 1'b0;
    soft_int_in = 1'b0; overflow_in = 1'b0; delay_slot_in = 1'b0;
    #12;
    chk("rst_pc",    {32'h0, PC_out},  {32'h0, RPC});
    chk("rst_pc4",   {32'h0, PC4_out}, {32'h0, RPC4});
    chk("rst_valid", {63'h0, mem_valid}, 64'h0);
    chk("rst_exc",   {63'h0, exc_pending}, 64'h0);

    // Load a valid load-word instruction.
    @(negedge clk);
    rst_n = 1'b1;
    ex_valid = 1'b1; PC_in = 32'h8000_0010; PC4_in = 32'h8000_0014;
    Inst_in = 32'h8D08_0004; alu_a_in = 32'h1000_0004; write_reg_in = 1'b1;
    write_dst_in = 5'd8; extOp_in = 3'b100; hilo_in = 64'h1234_5678_9ABC_DEF0;
    tick();
    chk("ld_pc",    {32'h0, PC_out},    64'h8000_0010);
    chk("ld_pc4",   {32'h0, PC4_out},   64'h8000_0014);
    chk("ld_alu_a", {32'h0, alu_a_out}, 64'h1000_0004);
    chk("ld_wreg",  {63'h0, write_reg_out}, 64'h1);
    chk("ld_dst",   {59'h0, write_dst_out}, 64'd8);
    chk("ld_ext",   {61'h0, extOp_out}, 64'h4);
    chk("ld_hilo",  hilo_out, 64'h1234_5678_9ABC_DEF0);
    chk("ld_valid", {63'h0, mem_valid}, 64'h1);

    // Stall three edges with new inputs present.
    stall = 1'b1; PC_in = 32'h8000_0020; alu_a_in = 32'h2000_0008; write_dst_in = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",  {32'h0, PC_out}, 64'h8000_0010);
      chk("stall_dst", {59'h0, write_dst_out}, 64'd8);
      chk("stall_valid", {63'h0, mem_valid}, 64'h1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc",  {32'h0, PC_out}, 64'h8000_0020);
    chk("unstall_alu", {32'h0, alu_a_out}, 64'h2000_0008);
    chk("unstall_dst", {59'h0, write_dst_out}, 64'd9);

    // Store with all byte enables, then flush together with stall.
    data_sram_wen_in = 4'hF; Inst_in = 32'hAD09_0000;
    tick();
    chk("st_wen", {60'h0, data_sram_wen_out}, 64'hF);
    flush = 1'b1; stall = 1'b1;
    tick();
    chk("fl_wen",   {60'h0, data_sram_wen_out}, 64'h0);
    chk("fl_inst",  {32'h0, Inst_out}, 64'h0);
    chk("fl_valid", {63'h0, mem_valid}, 64'h0);
    chk("fl_pc",    {32'h0, PC_out}, {32'h0, RPC});
    chk("fl_pc4",   {32'h0, PC4_out}, {32'h0, RPC4});
    flush = 1'b0; stall = 1'b0;

    // Invalid slot: side effects masked, datapath still loads.
    ex_valid = 1'b0; write_reg_in = 1'b1; write_dst_in = 5'd31; overflow_in = 1'b1;
    alu_a_in = 32'h3000_000C; data_sram_wen_in = 4'h3;
    tick();
    chk("inv_wreg", {63'h0, write_reg_out}, 64'h0);
    chk("inv_dst",  {59'h0, write_dst_out}, 64'h0);
    chk("inv_ovf",  {63'h0, overflow_out}, 64'h0);
    chk("inv_wen",  {60'h0, data_sram_wen_out}, 64'h0);
    chk("inv_exc",  {63'h0, exc_pending}, 64'h0);
    chk("inv_alu",  {32'h0, alu_a_out}, 64'h3000_000C);

    // Valid instruction without a GPR write: destination must read zero.
    ex_valid = 1'b1; overflow_in = 1'b0; write_reg_in = 1'b0; write_dst_in = 5'd7;
    data_sram_wen_in = 4'h0;
    tick();
    chk("nowr_dst", {59'h0, write_dst_out}, 64'h0);

    // Trap raises exc_pending; a bubble then clears it.
    trap_in = 1'b1; PC_in = 32'h8000_0040;
    tick();
    chk("trap_exc", {63'h0, exc_pending}, 64'h1);
    chk("trap_out", {63'h0, trap_out}, 64'h1);
    bubble = 1'b1;
    tick();
    chk("bub_exc",   {63'h0, exc_pending}, 64'h0);
    chk("bub_pc",    {32'h0, PC_out}, {32'h0, RPC});
    chk("bub_valid", {63'h0, mem_valid}, 64'h0);
    bubble = 1'b0; trap_in = 1'b0;

    // Stall and bubble together behave as stall.
    PC_in = 32'h8000_0050;
    tick();
    stall = 1'b1; bubble = 1'b1; PC_in = 32'h8000_0060;
    tick();
    chk("sb_pc",    {32'h0, PC_out}, 64'h8000_0050);
    chk("sb_valid", {63'h0, mem_valid}, 64'h1);
    bubble = 1'b0;

    // Asynchronous reset mid-cycle, released while stall stays high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc",    {32'h0, PC_out}, {32'h0, RPC});
    chk("arst_valid", {63'h0, mem_valid}, 64'h0);
    chk("arst_alu",   {32'h0, alu_a_out}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_stall_pc",    {32'h0, PC_out}, {32'h0, RPC});
    chk("rst_stall_valid", {63'h0, mem_valid}, 64'h0);
    stall = 1'b0;
    tick();
    chk("rel_pc",    {32'h0, PC_out}, 64'h8000_0060);
    chk("rel_valid", {63'h0, mem_valid}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS pipeline. Captures the full EX result bundle on each clock edge and presents it registered to MEM. Supports four per-cycle actions: hold on stall, bubble insertion, flush on exception/ERET, and reset to a defined PC. Adds a valid bit and an exception-pending summary for the hazard/CP0 logic.

Parameters:
RESET_PC, 32'hBFC0_0000, value of PC_out after reset/flush/bubble
RESET_PC4, 32'hBFC0_0004, value of PC4_out after reset/flush/bubble

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
stall  in  1  MEM stalled: hold every register
bubble  in  1  EX stalled while MEM advances: load a NOP
flush  in  1  exception/ERET flush: load a NOP
ex_valid  in  1  EX slot holds a real instruction
mem_valid  out  1  registered valid
PC_in/PC_out, PC4_in/PC4_out, Inst_in/Inst_out  in/out  32  PC, PC+4, instruction word
data_sram_wen_in/_out  in/out  4  store byte enables
data_sram_wdata_in/_out, reg_data1_in/_out, reg_data2_in/_out  in/out  32  store data, register operands
alu_a_in/_out, alu_s_in/_out, alu_c_in/_out  in/out  32  ALU result (memory address), shift result, aux result
hilo_in/_out  in/out  64  HI/LO write value
write_hilo_in/_out  in/out  2  HI/LO write enables
write_reg_in/_out, write_cp0reg_in/_out  in/out  1  GPR/CP0 write enables
write_dst_in/_out  in/out  5  destination register index
extOp_in/_out  in/out  3  load extension op (000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw)
write_data_src_in/_out  in/out  4  writeback mux select
trap_in/_out, IF_addr_fault_in/_out, ri_fault_in/_out, soft_int_in/_out, overflow_in/_out, delay_slot_in/_out  in/out  1  exception/status flags
exc_pending  out  1  mem_valid & (trap|IF_addr_fault|ri_fault|soft_int|overflow)_out

Behaviour:
- Reset (rst_n=0, asynchronous): mem_valid=0, PC_out=RESET_PC, PC4_out=RESET_PC4, every other output 0 (Inst_out=0 is the NOP). exc_pending=0.
- Per rising edge, priority: flush > stall > bubble > load.
- flush=1: load the NOP state (identical to reset values) regardless of stall. The instruction in the register is killed.
- stall=1 (flush=0): all registers hold, including mem_valid.
- bubble=1 (flush=0, stall=0): load the NOP state. The EX contents are discarded; EX keeps them itself.
- load (none asserted): every *_out <= *_in, mem_valid <= ex_valid.
- ex_valid=0 on load: side-effect fields are forced to 0: write_reg, write_cp0reg, write_hilo, data_sram_wen, all exception flags and delay_slot. Datapath fields still load.
- Latency: exactly 1 cycle from *_in to *_out. No combinational path from any input to any output except through rst_n.
- write_dst_out is forced to 0 whenever write_reg_out would be 0. The forwarding unit relies on this.
- exc_pending is combinational from registered outputs only.
- Reset deassertion mid-stall: the first edge after rst_n rises obeys normal priority. A held stall keeps the NOP state.
- stall and bubble both high: treated as stall, so bubble is ignored.

Decomposition:
- Package pipe_pkg: RESET_PC/RESET_PC4 defaults, extOp encodings, width constants (XLEN=32, HILO_W=64, WDS_W=4), NOP bundle constant.
- One sub-module, pipe_field_reg (parameter W, RST_VAL): async-reset register with hold/clear/load controls. Instantiated once per field group. The top level only decodes priority and masking.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with non-zero inputs -> outputs zero immediately, PC_out=32'hBFC00000, PC4_out=32'hBFC00004, mem_valid=0.
- Load: ex_valid=1, PC_in=32'h80000010, alu_a_in=32'h1000_0004, write_reg_in=1, write_dst_in=5'd8 -> next edge: same values out, mem_valid=1.
- Stall: after the load, stall=1 for 3 cycles with new inputs -> outputs unchanged for 3 edges, then update on the first edge with stall=0.
- Flush vs. stall: flush=1, stall=1 with data_sram_wen_in=4'hF -> next edge: data_sram_wen_out=0, Inst_out=0, mem_valid=0.
- Invalid slot: ex_valid=0, write_reg_in=1, write_dst_in=5'd31, overflow_in=1 -> write_reg_out=0, write_dst_out=0, overflow_out=0, exc_pending=0; alu_a_out still loaded.
- Bubble and exc_pending: load with trap_in=1 -> exc_pending=1; next edge bubble=1 -> exc_pending=0, PC_out=RESET_PC.
